// File: rtl/frame_loader.sv
// Packs twelve 32-bit stream words into a 384-bit frame for the slicer, first word in the MSBs.
// Define FRAME_LOADER_DOUBLE_BUFFER_EN to add a shadow buffer that fills while the slicer runs.
module frame_loader (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  i_tdata,
    input  logic         i_tvalid,
    output logic         o_tready,
    input  logic         i_tlast,
    input  logic         i_code_rate,
    output logic         o_code_rate,
    output logic [383:0] o_data_frame,
    output logic         o_en_s,
    input  logic         i_ood,
    output logic         o_last_frame
);
    // state | meaning
    // IDLE  | one cycle after reset
    // FILL  | accepting words into the frame
    // RUN   | frame held for the slicer, o_en_s high
    // DONE  | slicer finished, one-cycle turnaround
    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

    // Code rate encoding: 0 = rate 2, 1 = rate 3.
    localparam logic       CODE_RATE_2 = 1'b0;
    localparam int         WORDS       = 12;
    localparam logic [3:0] LAST_IDX    = 4'd11;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [383:0] frame_q, frame_d;
    logic         rate_q, rate_d;
    logic         last_q, last_d;

`ifdef FRAME_LOADER_DOUBLE_BUFFER_EN
    logic [383:0] sh_frame_q, sh_frame_d;
    logic [3:0]   sh_cnt_q, sh_cnt_d;
    logic         sh_rate_q, sh_rate_d;
    logic         sh_last_q, sh_last_d;
    logic         sh_full_q, sh_full_d;
`endif

    function automatic logic [383:0] put_word(input logic [383:0] base,
                                              input logic [3:0]   idx,
                                              input logic [31:0]  word);
        logic [383:0] res;
        res = base;
        for (int k = 0; k < WORDS; k++) begin
            if (idx == 4'(k)) res[383 - 32*k -: 32] = word;
        end
        return res;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        frame_d  = frame_q;
        rate_d   = rate_q;
        last_d   = last_q;
        o_tready = 1'b0;
`ifdef FRAME_LOADER_DOUBLE_BUFFER_EN
        sh_frame_d = sh_frame_q;
        sh_cnt_d   = sh_cnt_q;
        sh_rate_d  = sh_rate_q;
        sh_last_d  = sh_last_q;
        sh_full_d  = sh_full_q;
        if ((state_q == RUN || state_q == DONE) && i_tvalid && !sh_full_q) begin
            sh_frame_d = put_word((sh_cnt_q == 4'd0) ? '0 : sh_frame_q, sh_cnt_q, i_tdata);
            if (sh_cnt_q == 4'd0) sh_rate_d = i_code_rate;
            sh_cnt_d = sh_cnt_q + 4'd1;
            if (i_tlast) sh_last_d = 1'b1;
            if (i_tlast || sh_cnt_q == LAST_IDX) sh_full_d = 1'b1;
        end
`endif
        case (state_q)
            IDLE: begin
                state_d = FILL;
                cnt_d   = '0;
            end
            FILL: begin
                o_tready = 1'b1;
                if (i_tvalid) begin
                    // Clearing on word 0 provides the zero fill for short packets.
                    frame_d = put_word((cnt_q == 4'd0) ? '0 : frame_q, cnt_q, i_tdata);
                    if (cnt_q == 4'd0) rate_d = i_code_rate;
                    cnt_d = cnt_q + 4'd1;
                    if (i_tlast) last_d = 1'b1;
                    if (i_tlast || cnt_q == LAST_IDX) state_d = RUN;
                end
            end
            RUN: begin
`ifdef FRAME_LOADER_DOUBLE_BUFFER_EN
                o_tready = !sh_full_q;
`endif
                if (i_ood) state_d = DONE;
            end
            DONE: begin
                state_d = FILL;
                cnt_d   = '0;
                last_d  = 1'b0;
`ifdef FRAME_LOADER_DOUBLE_BUFFER_EN
                o_tready = !sh_full_q;
                if (sh_full_d) begin
                    state_d = RUN;
                    frame_d = sh_frame_d;
                    rate_d  = sh_rate_d;
                    last_d  = sh_last_d;
                end else if (sh_cnt_d != 4'd0) begin
                    frame_d = sh_frame_d;
                    rate_d  = sh_rate_d;
                    cnt_d   = sh_cnt_d;
                end
                sh_cnt_d  = '0;
                sh_full_d = 1'b0;
                sh_last_d = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            frame_q <= '0;
            rate_q  <= CODE_RATE_2;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            rate_q  <= rate_d;
            last_q  <= last_d;
        end
    end

`ifdef FRAME_LOADER_DOUBLE_BUFFER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_frame_q <= '0;
            sh_cnt_q   <= '0;
            sh_rate_q  <= CODE_RATE_2;
            sh_last_q  <= 1'b0;
            sh_full_q  <= 1'b0;
        end else begin
            sh_frame_q <= sh_frame_d;
            sh_cnt_q   <= sh_cnt_d;
            sh_rate_q  <= sh_rate_d;
            sh_last_q  <= sh_last_d;
            sh_full_q  <= sh_full_d;
        end
    end
`endif

    assign o_en_s       = (state_q == RUN);
    assign o_data_frame = frame_q;
    assign o_code_rate  = rate_q;
    assign o_last_frame = last_q;

endmodule

// File: tb/tb_frame_loader.sv
// Directed and randomized bench for frame_loader (default single-buffer build).
module tb_frame_loader;
    localparam logic CODE_RATE_2 = 1'b0;
    localparam logic CODE_RATE_3 = 1'b1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  i_tdata = '0;
    logic         i_tvalid = 1'b0;
    logic         o_tready;
    logic         i_tlast = 1'b0;
    logic         i_code_rate = 1'b0;
    logic         o_code_rate;
    logic [383:0] o_data_frame;
    logic         o_en_s;
    logic         i_ood = 1'b0;
    logic         o_last_frame;

    int checks = 0;
    int errors = 0;

    logic [31:0]  w [12];
    logic         r [12];
    logic [383:0] exp_frame;
    logic         exp_rate;
    logic         exp_last;

    frame_loader dut (
        .clk          (clk),
        .rst          (rst),
        .i_tdata      (i_tdata),
        .i_tvalid     (i_tvalid),
        .o_tready     (o_tready),
        .i_tlast      (i_tlast),
        .i_code_rate  (i_code_rate),
        .o_code_rate  (o_code_rate),
        .o_data_frame (o_data_frame),
        .o_en_s       (o_en_s),
        .i_ood        (i_ood),
        .o_last_frame (o_last_frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: words shifted in MSB-first, missing words are zero.
    function automatic logic [383:0] model_frame(input int n);
        logic [383:0] f;
        f = '0;
        for (int i = 0; i < 12; i++) f = {f[351:0], (i < n) ? w[i] : 32'h0};
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input int i, input bit is_last, input bit is_final, input int max_gap);
        bit rdy;
        int guard;
        repeat ($urandom_range(max_gap)) begin
            i_tvalid    = 1'b0;
            i_tdata     = $urandom;
            i_tlast     = 1'($urandom);
            i_ood       = 1'($urandom);
            i_code_rate = 1'($urandom);
            step();
            check("fill_gap_en", o_en_s, 1'b0);
        end
        i_tvalid    = 1'b1;
        i_tdata     = w[i];
        i_tlast     = is_last;
        i_code_rate = r[i];
        i_ood       = 1'($urandom);
        rdy   = 1'b0;
        guard = 0;
        while (!rdy && guard < 20) begin
            rdy = o_tready;
            step();
            guard++;
        end
        if (!rdy) check("tready_wait", rdy, 1'b1);
        check(is_final ? "run_entry_en" : "fill_en", o_en_s, is_final);
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        i_ood    = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit has_last, input int max_gap);
        for (int i = 0; i < n; i++)
            push_word(i, has_last && (i == n - 1), i == n - 1, max_gap);
        exp_frame = model_frame(n);
        exp_rate  = r[0];
        exp_last  = has_last;
        check("frame", o_data_frame, exp_frame);
        check("code_rate", o_code_rate, exp_rate);
        check("last_frame", o_last_frame, exp_last);
        check("run_tready", o_tready, 1'b0);
    endtask

    task automatic run_and_done(input int k);
        for (int c = 0; c < k; c++) begin
            i_ood = 1'b0;
            step();
            check("run_en", o_en_s, 1'b1);
            check("run_stable", o_data_frame, exp_frame);
            check("run_tready", o_tready, 1'b0);
        end
        i_ood = 1'b1;
        step();
        i_ood = 1'b0;
        check("done_en", o_en_s, 1'b0);
        check("done_tready", o_tready, 1'b0);
        check("done_frame", o_data_frame, exp_frame);
        step();
        check("post_done_tready", o_tready, 1'b1);
        check("post_done_en", o_en_s, 1'b0);
        check("post_done_last", o_last_frame, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tready"}, o_tready, 1'b0);
        check({tag, "_en"}, o_en_s, 1'b0);
        check({tag, "_frame"}, o_data_frame, 384'h0);
        check({tag, "_rate"}, o_code_rate, 1'b0);
        check({tag, "_last"}, o_last_frame, 1'b0);
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        check_reset_outputs({tag, "_async"});
        step();
        rst = 1'b0;
        check_reset_outputs({tag, "_held"});
        step();
        check({tag, "_idle_exit_tready"}, o_tready, 1'b1);
    endtask

    initial begin
        int n;
        bit has_last;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        check("idle_tready", o_tready, 1'b0);
        step();
        check("fill_tready", o_tready, 1'b1);

        // Twelve ascending words at rate 2.
        for (int i = 0; i < 12; i++) begin
            w[i] = 32'(i + 1);
            r[i] = CODE_RATE_2;
        end
        send_frame(12, 1'b0, 0);
        check("first_word_msb", o_data_frame[383:352], 32'h0000_0001);
        check("last_word_lsb", o_data_frame[31:0], 32'h0000_000C);
        run_and_done(5);

        // Short packet with tlast on word 3.
        for (int i = 0; i < 12; i++) begin
            w[i] = 32'hFFFF_FFFF;
            r[i] = CODE_RATE_3;
        end
        send_frame(3, 1'b1, 1);
        check("short_ones", o_data_frame[383:288], {96{1'b1}});
        check("short_zero", o_data_frame[287:0], 288'h0);
        run_and_done(2);

        // Code rate changes after word 0 must not affect the latched rate.
        for (int i = 0; i < 12; i++) begin
            w[i] = $urandom;
            r[i] = (i == 0) ? CODE_RATE_2 : CODE_RATE_3;
        end
        send_frame(12, 1'b0, 1);
        check("rate_latched_w0", o_code_rate, CODE_RATE_2);
        run_and_done(1);

        // tlast on the final word of a full frame.
        for (int i = 0; i < 12; i++) begin
            w[i] = $urandom;
            r[i] = 1'($urandom);
        end
        send_frame(12, 1'b1, 2);
        run_and_done(0);

        // Randomized packets.
        for (int f = 0; f < 8; f++) begin
            n = $urandom_range(12, 1);
            has_last = (n < 12) ? 1'b1 : 1'($urandom);
            for (int i = 0; i < 12; i++) begin
                w[i] = $urandom;
                r[i] = 1'($urandom);
            end
            send_frame(n, has_last, 2);
            run_and_done($urandom_range(6));
        end

        // Reset in the middle of RUN, then a fresh frame.
        for (int i = 0; i < 12; i++) begin
            w[i] = $urandom;
            r[i] = CODE_RATE_3;
        end
        send_frame(12, 1'b0, 0);
        step();
        pulse_reset("rst_run");
        for (int i = 0; i < 12; i++) begin
            w[i] = $urandom;
            r[i] = 1'($urandom);
        end
        send_frame(12, 1'b0, 1);
        run_and_done(3);

        // Reset in the middle of FILL discards the partial frame.
        for (int i = 0; i < 12; i++) begin
            w[i] = $urandom;
            r[i] = CODE_RATE_3;
        end
        for (int i = 0; i < 5; i++) push_word(i, 1'b0, 1'b0, 0);
        pulse_reset("rst_fill");
        for (int i = 0; i < 12; i++) begin
            w[i] = $urandom;
            r[i] = CODE_RATE_2;
        end
        send_frame(3, 1'b1, 0);
        run_and_done(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
endmodule
